// File: rtl/minibyte_alu_seq.sv
// rtl/minibyte_alu_seq.sv - registered MiniByte ALU with start/busy/done handshake and Z/N/C flags
// Optional multiplier datapath enabled by defining MINIBYTE_ALU_MUL_EN.
module minibyte_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] res_out,
    output logic             flag_z_out,
    output logic             flag_n_out,
    output logic             flag_c_out
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
`ifdef MINIBYTE_ALU_MUL_EN
    localparam int WW  = 2 * WIDTH;
`else
    localparam int WW  = WIDTH;
`endif

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state;
    logic [2:0]    op_r;
    logic [WW-1:0] work;
    logic [CW-1:0] cnt;
`ifdef MINIBYTE_ALU_MUL_EN
    logic [WIDTH-1:0] a_r;
    logic [WIDTH:0]   mul_acc;
`endif

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             is_shift;
    logic [WW-1:0]    step_work;
    logic             step_c;

    // Single-cycle result, computed straight from the inputs on the accepting edge.
    always_comb begin
        sum_ext  = {1'b0, a_in} + {1'b0, b_in};
        diff_ext = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
        sc_res   = a_in;
        sc_c     = 1'b0;
        case (op_in)
            OP_ADD: begin sc_res = sum_ext[WIDTH-1:0];  sc_c = sum_ext[WIDTH];   end
            OP_SUB: begin sc_res = diff_ext[WIDTH-1:0]; sc_c = ~diff_ext[WIDTH]; end
            OP_AND: sc_res = a_in & b_in;
            OP_OR:  sc_res = a_in | b_in;
            OP_XOR: sc_res = a_in ^ b_in;
            default: ;
        endcase
        is_shift = ((op_in == OP_SHL) || (op_in == OP_SHR)) && (b_in[SHW-1:0] != '0);
    end

    // One iteration of the multi-cycle datapath; the multiply accumulates into the upper half.
    always_comb begin
        step_work = '0;
        step_c    = 1'b0;
`ifdef MINIBYTE_ALU_MUL_EN
        mul_acc   = '0;
`endif
        case (op_r)
            OP_SHL: begin
                step_work[WIDTH-1:0] = {work[WIDTH-2:0], 1'b0};
                step_c               = work[WIDTH-1];
            end
            OP_SHR: begin
                step_work[WIDTH-1:0] = {1'b0, work[WIDTH-1:1]};
                step_c               = work[0];
            end
`ifdef MINIBYTE_ALU_MUL_EN
            default: begin
                mul_acc   = {1'b0, work[WW-1:WIDTH]} + (work[0] ? {1'b0, a_r} : '0);
                step_work = {mul_acc, work[WIDTH-1:1]};
                step_c    = |step_work[WW-1:WIDTH];
            end
`else
            default: ;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_r       <= '0;
            work       <= '0;
            cnt        <= '0;
`ifdef MINIBYTE_ALU_MUL_EN
            a_r        <= '0;
`endif
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            res_out    <= '0;
            flag_z_out <= 1'b0;
            flag_n_out <= 1'b0;
            flag_c_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op_r <= op_in;
                        if (is_shift) begin
                            work     <= WW'(a_in);
                            cnt      <= {1'b0, b_in[SHW-1:0]};
                            state    <= EXEC;
                            busy_out <= 1'b1;
                        end
`ifdef MINIBYTE_ALU_MUL_EN
                        else if (op_in == OP_MUL) begin
                            a_r      <= a_in;
                            work     <= WW'(b_in);
                            cnt      <= CW'(WIDTH);
                            state    <= EXEC;
                            busy_out <= 1'b1;
                        end
`endif
                        else begin
                            res_out    <= sc_res;
                            flag_z_out <= (sc_res == '0);
                            flag_n_out <= sc_res[WIDTH-1];
                            flag_c_out <= sc_c;
                            done_out   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    work <= step_work;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        res_out    <= step_work[WIDTH-1:0];
                        flag_z_out <= (step_work[WIDTH-1:0] == '0);
                        flag_n_out <= step_work[WIDTH-1];
                        flag_c_out <= step_c;
                        done_out   <= 1'b1;
                        busy_out   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/minibyte_alu_seq.md
# minibyte_alu_seq

Registered, parametrised successor to the MiniByte combinational ALU. Adds a start/busy/done handshake, iterative shift-by-N and shift-add multiply, and a registered Z/N/C flag set. Sits between the MiniByte control FSM and the register file; the control FSM issues one operation at a time and waits for `done_out`.

## Interface
- `WIDTH`, 8: datapath width in bits; power of two, 4..32.
- `SHW`, `$clog2(WIDTH)`: shift-count width (localparam, not overridable).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_in`  in  1  request; sampled only when `busy_out`=0.
- `op_in`  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- `a_in`  in  WIDTH  operand A.
- `b_in`  in  WIDTH  operand B; for SHL/SHR only `b_in[SHW-1:0]` is the count.
- `busy_out`  out  1  operation in progress.
- `done_out`  out  1  one-cycle pulse; result and flags valid from this cycle.
- `res_out`  out  WIDTH  result, held until the next `done_out`.
- `flag_z_out`  out  1  result == 0.
- `flag_n_out`  out  1  result MSB.
- `flag_c_out`  out  1  carry/borrow/shift-out/overflow.

## Operation
- States: IDLE, EXEC. Reset forces IDLE. All outputs are 0 in reset and on reset release.
- Accept: `start_in`=1 in IDLE latches `op_in`, `a_in` and `b_in` into internal registers. Operand changes after accept are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, and SHL/SHR with count 0): result is computed and registered on the accepting edge. Stays IDLE. `done_out` is high the next cycle.
- SHL/SHR with count k>0: enter EXEC with counter=k. Shift the working register 1 bit per cycle with zero fill, decrementing the counter. On the edge where the counter reaches 0, register the result, return to IDLE and pulse `done_out`.
- MUL: unsigned shift-add over WIDTH cycles in EXEC. Full 2·WIDTH product is formed internally. `res_out` is the low WIDTH bits.
- Arithmetic is unsigned modulo 2^WIDTH. SUB is a + ~b + 1.
- Carry rules:
  - ADD: carry out of the MSB.
  - SUB: borrow, i.e. a < b unsigned.
  - SHL/SHR: the last bit shifted out; 0 if k=0.
  - MUL: high half nonzero.
  - AND/OR/XOR: 0.
- Flags and `res_out` update only on the edge that raises `done_out`. At all other times they hold their values.
- `start_in` while `busy_out`=1 is ignored; there is no queueing.
- Back-to-back: `start_in` in the same cycle as `done_out` (IDLE) is accepted.
- Undefined opcodes: none; all 8 codes are defined.

## Timing
- Let the accept edge be E0.
- Single-cycle ops: `done_out`=1 in the cycle after E0. Latency 1. `busy_out` never rises.
- Shift, k>0: `busy_out`=1 for cycles E0..E0+k−1. `done_out`=1 after edge E0+k. Latency k+1.
- MUL: `busy_out`=1 for WIDTH cycles. `done_out` is asserted after edge E0+WIDTH. Latency WIDTH+1.
- `done_out` and `busy_out` are never high in the same cycle.
- Reset asserted mid-operation aborts immediately: IDLE, all outputs 0, no `done_out`.
- Throughput: one single-cycle op per clock.

## Configuration
- `MINIBYTE_ALU_MUL_EN` defined: MUL as described above, including its datapath and counter.
- Not defined: no multiply hardware. Opcode 7 behaves as a single-cycle op with `res_out`=`a_in` and `flag_c_out`=0. Z/N are computed from `a_in`. Latency is 1.

## Test plan
- Reset: hold `rst_n`=0 with `start_in`=1 and random operands → all outputs 0. After release with `start_in`=0, outputs stay 0.
- ADD then SUB back-to-back (WIDTH=8):
  - 0xF0+0x20 → `res_out`=0x10, C=1, Z=0, N=0, one cycle after accept.
  - Next cycle, 0x05−0x05 → 0x00, Z=1, C=0.
- SHL of 0x81 by 3 → `busy_out` for 3 cycles, `done_out` on cycle 4, `res_out`=0x08, C=0.
  - SHR of 0x81 by 1 → 0x40, C=1, latency 2.
- MUL 0x10·0x11 (macro defined) → 0x10 low byte, C=1, `done_out` exactly 9 cycles after accept. Macro undefined → 0x10, C=0, latency 1.
- `start_in` pulsed during a busy shift with different operands → ignored; the original result is delivered unchanged.
- Reset pulse mid-MUL → `busy_out` drops asynchronously, no `done_out`. A fresh ADD 1+1 afterwards → 0x02.
